// File: rtl/keypad_scanner.sv
// Pmod KYPD 4x4 scanner: active-low column drive, row sync,
// frame-based debounce, one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int SCAN_WIDTH     = 18,
  parameter int SCAN_LIMIT     = 200000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [SCAN_WIDTH-1:0] LAST =
    SCAN_WIDTH'(SCAN_LIMIT - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  logic [3:0]            row_s1;
  logic [3:0]            row_s2;
  logic [SCAN_WIDTH-1:0] prescaler;
  logic [1:0]            col_idx;
  logic [15:0]           acc;
  state_t                state;
  logic [3:0]            count;
  logic [3:0]            cand;

  logic        tick;
  logic        frame_end;
  logic [15:0] frame;
  logic [4:0]  ones;
  logic [3:0]  hit;
  logic [3:0]  hit_key;
  logic        none;
  logic        single;
  logic [3:0]  cnt_inc;

  function automatic logic [3:0] key_of(
    input logic [3:0] idx
  );
    logic [3:0] k;
    unique case (idx)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'h0;
      4'd13: k = 4'hF;
      4'd14: k = 4'hE;
      4'd15: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick      = (prescaler == LAST);
  assign frame_end = tick && (col_idx == 2'd3);

  // accumulator holds pressed bits active-high; merge current column
  always_comb begin
    frame = acc;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) frame[r*4 + int'(col_idx)] = 1'b1;
    end
  end

  always_comb begin
    ones = 5'd0;
    hit  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        ones = ones + 5'd1;
        hit  = i[3:0];
      end
    end
  end

  assign hit_key = key_of(hit);
  assign none    = (ones == 5'd0);
  assign single  = (ones == 5'd1);
  assign cnt_inc = (count == 4'hF) ? count : count + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      acc       <= 16'd0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        col_idx <= col_idx + 2'd1;
        col     <= ~(4'b0001 << (col_idx + 2'd1));
        acc     <= frame_end ? 16'd0 : frame;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RELEASED;
      count     <= 4'd0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        unique case (state)
          RELEASED: begin
            if (single) begin
              state <= PRESS_WAIT;
              cand  <= hit_key;
              count <= 4'd1;
            end
          end
          PRESS_WAIT: begin
            if (single && hit_key == cand) begin
              count <= cnt_inc;
              if (cnt_inc == DB) begin
                state     <= HELD;
                count     <= 4'd0;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (single) begin
              cand  <= hit_key;
              count <= 4'd1;
            end else begin
              state <= RELEASED;
              count <= 4'd0;
            end
          end
          HELD: begin
            if (none) begin
              state <= RELEASE_WAIT;
              count <= 4'd1;
            end
          end
          RELEASE_WAIT: begin
            if (none) begin
              count <= cnt_inc;
              if (cnt_inc == DB) begin
                state    <= RELEASED;
                count    <= 4'd0;
                key_held <= 1'b0;
              end
            end else begin
              state <= HELD;
              count <= 4'd0;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model on col/row, frame-aligned
// stimulus segments with queued expectations, plus reset sequences.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'd0;

  localparam logic [15:0] KN = 16'h0000;
  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K2 = 16'h0002;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K7 = 16'h0100;
  localparam logic [15:0] K8 = 16'h0200;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KF = 16'h2000;
  localparam logic [15:0] KD = 16'h8000;

  always #5 clock = ~clock;

  // switch matrix: a pressed key pulls its row low while its column is low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_WIDTH(18),
    .SCAN_LIMIT(4),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t       vecs[$];
  vec_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  int         dbl = 0;
  logic       last_valid = 1'b0;
  logic [3:0] prev_col = 4'b1110;

  always @(negedge clock) begin
    if (key_valid && last_valid) dbl++;
    last_valid = key_valid;
  end

  task automatic check(input string name, input int act,
                       input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int f = 0;
    int cyc = 0;
    while (f < n && cyc < n*16 + 40) begin
      @(negedge clock);
      cyc++;
      if (key_valid) pulses++;
      if (prev_col == 4'b0111 && col == 4'b1110) f++;
      prev_col = col;
    end
    if (f < n) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d frames expected %0d",
               f, n);
    end
  endtask

  function automatic void add(input logic [15:0] k, input int f,
                              input int p, input logic [3:0] c,
                              input logic h);
    vec_t v;
    v.keys   = k;
    v.frames = f;
    v.pulses = p;
    v.code   = c;
    v.held   = h;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t e;

    add(KN, 10, 0, 4'h0, 1'b0);
    add(K5, 3, 0, 4'h0, 1'b0);
    add(K5, 1, 1, 4'h5, 1'b1);
    add(K5, 20, 0, 4'h5, 1'b1);
    add(KN, 2, 0, 4'h5, 1'b1);
    add(K5, 1, 0, 4'h5, 1'b1);
    add(KN, 3, 0, 4'h5, 1'b1);
    add(KN, 1, 0, 4'h5, 1'b0);
    add(KA, 3, 0, 4'h5, 1'b0);
    add(KA, 1, 1, 4'hA, 1'b1);
    add(KN, 4, 0, 4'hA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(K9, 2, 0, 4'hA, 1'b0);
      add(KN, 1, 0, 4'hA, 1'b0);
    end
    add(K1 | K2, 10, 0, 4'hA, 1'b0);
    add(K1, 3, 0, 4'hA, 1'b0);
    add(K1, 1, 1, 4'h1, 1'b1);
    add(KF, 2, 0, 4'h1, 1'b1);
    add(KN, 4, 0, 4'h1, 1'b0);
    add(K7, 2, 0, 4'h1, 1'b0);
    add(K8, 3, 0, 4'h1, 1'b0);
    add(K8, 1, 1, 4'h8, 1'b1);
    add(KN, 4, 0, 4'h8, 1'b0);

    repeat (3) @(negedge clock);
    check("rst_col", int'(col), 4'he);
    check("rst_code", int'(key_code), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);

    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] ec;
      @(negedge clock);
      ec = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("col_step%0d", i), int'(col), int'(ec));
      prev_col = col;
    end

    foreach (vecs[i]) begin
      keys   = vecs[i].keys;
      sb.push_back(vecs[i]);
      pulses = 0;
      wait_frames(vecs[i].frames);
      e = sb.pop_front();
      check($sformatf("seg%0d_pulses", i), pulses, e.pulses);
      check($sformatf("seg%0d_code", i), int'(key_code),
            int'(e.code));
      check($sformatf("seg%0d_held", i), int'(key_held),
            int'(e.held));
    end

    keys = KD;
    wait_frames(2);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_col", int'(col), 4'he);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_held", int'(key_held), 0);
    repeat (3) @(negedge clock);
    reset    = 1'b1;
    prev_col = col;
    pulses   = 0;
    wait_frames(3);
    check("post_rst3_pulses", pulses, 0);
    check("post_rst3_held", int'(key_held), 0);
    wait_frames(1);
    check("post_rst4_pulses", pulses, 1);
    check("post_rst4_code", int'(key_code), 4'hd);
    check("post_rst4_held", int'(key_held), 1);

    check("no_double_pulse", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
